bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for four requesters sharing one tri-state bus line.
- Sits directly upstream of the tri-state bus driver and produces its `sel[1:0]` and `enable` inputs.
- Guarantees at most one driver at a time.
- Inserts idle turnaround cycles between owners so two sources never drive the bus in the same cycle.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced rotation when another requester waits. Used only with the optional feature. Must be >= 1.
- TURN_CYCLES, 1: cycles with enable low between release and next grant. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i high = requester i wants the bus.
- sel  output  2  index of current/last owner; drives buffer select.
- enable  output  1  high while a grant is active; drives buffer enable.
- grant  output  4  one-hot grant, equal to (1<<sel) when enable=1, else 0.
- busy  output  1  high in GRANT or TURN states.

Behaviour:
- All outputs are registered. The state machine has three states: IDLE, GRANT, TURN.
- Internal registers:
  - last_winner (2 bits), reset value 3, so requester 0 has first priority.
  - hold_cnt, width $clog2(MAX_HOLD+1).
  - turn_cnt, width $clog2(TURN_CYCLES+1).
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - sel=0, enable=0, grant=0, busy=0.
  - hold_cnt=0, turn_cnt=0, last_winner=3.
  - Reset overrides everything, including mid-grant: enable falls at the reset edge, with no turnaround.
- Winner selection:
  - Search req for the first set bit, starting at (last_winner+1) mod 4 and wrapping 3->0.
  - Bits of req other than the winner are ignored.
- IDLE:
  - If req != 0: next state GRANT, sel=winner, enable=1, grant=onehot(winner), last_winner=winner, hold_cnt=1.
  - Latency: req high before edge k gives enable high after edge k (one cycle).
  - Otherwise stay in IDLE with outputs unchanged (sel holds its last value).
- GRANT:
  - Each cycle, hold_cnt increments and saturates at MAX_HOLD.
  - If req[sel]=0: go to TURN.
  - Else if a preemption condition holds (optional feature): go to TURN.
  - Else stay in GRANT.
  - Entering TURN sets enable=0, grant=0, turn_cnt=1. sel is unchanged.
- TURN:
  - While turn_cnt < TURN_CYCLES: increment turn_cnt.
  - When turn_cnt == TURN_CYCLES: arbitrate as in IDLE. If req != 0, go to GRANT with the new winner; otherwise go to IDLE.
  - Result: enable is low for exactly TURN_CYCLES cycles between any two grants.
  - The same requester may win again if it is the only requester.
- Simultaneous events:
  - Owner drops req in the same cycle as a timeout: single transition to TURN, no double count.
  - A new req arriving during TURN is honoured at TURN exit, in round-robin order.
- busy = (state != IDLE).
- Invariant: popcount(grant) <= 1 every cycle.
- Invariant: enable == |grant.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD and (req & ~onehot(sel)) != 0, the owner is preempted and the state goes to TURN even though req[sel]=1.
  - With no competing requester, the grant continues indefinitely; hold_cnt stays saturated.
- Undefined:
  - The owner keeps the bus until it drops req.
  - MAX_HOLD is unused; hold_cnt logic is absent.

Test Plan (MAX_HOLD=8, TURN_CYCLES=1 unless noted):
- Reset: rst=1 for 2 cycles with req=4'b1111 -> sel=0, enable=0, grant=0, busy=0 throughout. After rst falls, requester 0 is granted at the next edge.
- Single request: req=4'b0100 from cycle 0, dropped at cycle 5.
  - Next edge: enable=1, sel=2, grant=4'b0100.
  - After req drops: one cycle with enable=0, busy=1, then IDLE with busy=0.
- Timeout rotation (macro defined): req=4'b1111 held -> grants in order 0,1,2,3,0. Each grant has enable high for 8 cycles, separated by exactly 1 low cycle.
- No timeout (macro undefined): req=4'b1111 for 50 cycles -> sel=0 and enable=1 continuously. Then clear req[0] -> 1 turn cycle, then sel=1.
- Timeout without competitor (macro defined): req=4'b0001 for 20 cycles -> enable stays high with no gap at cycle 8.
- Reset mid-grant: sel=3 granted, assert rst for 1 cycle.
  - Enable=0 at that edge.
  - With req=4'b1001 held, the next grant goes to requester 0 (last_winner reset to 3).

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with turnaround cycles for a shared tri-state bus line.
// Define BUS_ARBITER_TIMEOUT_EN to enable forced rotation after MAX_HOLD cycles.
module bus_arbiter #(
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       enable,
    output logic [3:0] grant,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    localparam int TW = (TURN_CYCLES < 1) ? 1 : $clog2(TURN_CYCLES + 1);
    localparam logic [TW-1:0] TURN_MAX = TW'(TURN_CYCLES);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be >= 1");
    end
    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("TURN_CYCLES must be >= 1");
    end

    logic [1:0]    state;
    logic [1:0]    last_winner;
    logic [TW-1:0] turn_cnt;
    logic [1:0]    win;
    logic [3:0]    win_oh;
    logic          preempt;

    // Rotating search starting just after the previous owner.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_winner + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign win_oh = 4'b0001 << win;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic [HW-1:0] hold_cnt;

    assign preempt = (hold_cnt == HOLD_MAX) && |(req & ~grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 1'b1;
        end else if ((state == IDLE || (state == TURN && turn_cnt == TURN_MAX))
                     && |req) begin
            hold_cnt <= HW'(1);
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 2'd0;
            enable      <= 1'b0;
            grant       <= 4'b0;
            busy        <= 1'b0;
            turn_cnt    <= '0;
            last_winner <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state       <= GRANT;
                        sel         <= win;
                        enable      <= 1'b1;
                        grant       <= win_oh;
                        busy        <= 1'b1;
                        last_winner <= win;
                    end
                end
                GRANT: begin
                    if (!req[sel] || preempt) begin
                        state    <= TURN;
                        enable   <= 1'b0;
                        grant    <= 4'b0;
                        turn_cnt <= TW'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt != TURN_MAX) begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end else if (|req) begin
                        state       <= GRANT;
                        sel         <= win;
                        enable      <= 1'b1;
                        grant       <= win_oh;
                        last_winner <= win;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    grant  <= 4'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_HOLD=8, TURN_CYCLES=1).
// Timeout scenarios run only when BUS_ARBITER_TIMEOUT_EN is defined.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0;
    logic [1:0] sel;
    logic       enable;
    logic [3:0] grant;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .sel    (sel),
        .enable (enable),
        .grant  (grant),
        .busy   (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({sel, enable, grant, busy} !== 8'b0) begin
                bad++;
                $display("FAIL reset_outputs got=%b required=%b",
                         {sel, enable, grant, busy}, 8'b0);
            end
        end
        rst = 1'b0;
        step();
        total++;
        if ({sel, enable, grant, busy} !== {2'd0, 1'b1, 4'b0001, 1'b1}) begin
            bad++;
            $display("FAIL reset_first_grant got=%b required=%b",
                     {sel, enable, grant, busy}, {2'd0, 1'b1, 4'b0001, 1'b1});
        end
        req = 4'b0;
        step();
        total++;
        if ({enable, grant, busy} !== {1'b0, 4'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release_turn got=%b required=%b",
                     {enable, grant, busy}, {1'b0, 4'b0, 1'b1});
        end
        step();
        total++;
        if ({enable, busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_back_idle got=%b required=%b",
                     {enable, busy}, 2'b00);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({sel, enable, grant} !== {2'd2, 1'b1, 4'b0100}) begin
                bad++;
                $display("FAIL single_grant cyc=%0d got=%b required=%b",
                         i, {sel, enable, grant}, {2'd2, 1'b1, 4'b0100});
            end
        end
        req = 4'b0;
        step();
        total++;
        if ({sel, enable, grant, busy} !== {2'd2, 1'b0, 4'b0, 1'b1}) begin
            bad++;
            $display("FAIL single_turn got=%b required=%b",
                     {sel, enable, grant, busy}, {2'd2, 1'b0, 4'b0, 1'b1});
        end
        step();
        total++;
        if ({sel, enable, busy} !== {2'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_idle got=%b required=%b",
                     {sel, enable, busy}, {2'd2, 1'b0, 1'b0});
        end
        step();
        total++;
        if ({sel, enable, busy} !== {2'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_idle_hold got=%b required=%b",
                     {sel, enable, busy}, {2'd2, 1'b0, 1'b0});
        end
    endtask

    task automatic test_no_timeout();
        int errs;
        do_reset();
        req  = 4'b1111;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ({sel, enable, grant} !== {2'd0, 1'b1, 4'b0001}) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL no_timeout_hold bad_cycles got=%0d required=0", errs);
        end
        req = 4'b1110;
        step();
        total++;
        if ({enable, grant, busy} !== {1'b0, 4'b0, 1'b1}) begin
            bad++;
            $display("FAIL no_timeout_turn got=%b required=%b",
                     {enable, grant, busy}, {1'b0, 4'b0, 1'b1});
        end
        step();
        total++;
        if ({sel, enable, grant} !== {2'd1, 1'b1, 4'b0010}) begin
            bad++;
            $display("FAIL no_timeout_next got=%b required=%b",
                     {sel, enable, grant}, {2'd1, 1'b1, 4'b0010});
        end
    endtask

    task automatic test_timeout_rotation();
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                total++;
                if ({sel, enable, grant} !== {order[g], 1'b1, 4'b0001 << order[g]}) begin
                    bad++;
                    $display("FAIL timeout_grant g=%0d c=%0d got=%b required=%b",
                             g, c, {sel, enable, grant},
                             {order[g], 1'b1, 4'b0001 << order[g]});
                end
                step();
            end
            total++;
            if ({enable, grant, busy} !== {1'b0, 4'b0, 1'b1}) begin
                bad++;
                $display("FAIL timeout_gap g=%0d got=%b required=%b",
                         g, {enable, grant, busy}, {1'b0, 4'b0, 1'b1});
            end
            step();
        end
    endtask

    task automatic test_timeout_alone();
        int errs;
        do_reset();
        req  = 4'b0001;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({sel, enable, grant} !== {2'd0, 1'b1, 4'b0001}) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL timeout_alone bad_cycles got=%0d required=0", errs);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b1000;
        step();
        step();
        total++;
        if ({sel, enable, grant} !== {2'd3, 1'b1, 4'b1000}) begin
            bad++;
            $display("FAIL midrst_owner got=%b required=%b",
                     {sel, enable, grant}, {2'd3, 1'b1, 4'b1000});
        end
        rst = 1'b1;
        req = 4'b1001;
        step();
        total++;
        if ({sel, enable, grant, busy} !== 8'b0) begin
            bad++;
            $display("FAIL midrst_drop got=%b required=%b",
                     {sel, enable, grant, busy}, 8'b0);
        end
        rst = 1'b0;
        step();
        total++;
        if ({sel, enable, grant} !== {2'd0, 1'b1, 4'b0001}) begin
            bad++;
            $display("FAIL midrst_regrant got=%b required=%b",
                     {sel, enable, grant}, {2'd0, 1'b1, 4'b0001});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0110;
        step();
        total++;
        if ({sel, grant} !== {2'd1, 4'b0010}) begin
            bad++;
            $display("FAIL b2b_first got=%b required=%b",
                     {sel, grant}, {2'd1, 4'b0010});
        end
        req = 4'b0100;
        step();
        total++;
        if ({enable, busy} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_turn1 got=%b required=%b", {enable, busy}, 2'b01);
        end
        req = 4'b0101;
        step();
        total++;
        if ({sel, enable, grant} !== {2'd2, 1'b1, 4'b0100}) begin
            bad++;
            $display("FAIL b2b_second got=%b required=%b",
                     {sel, enable, grant}, {2'd2, 1'b1, 4'b0100});
        end
        req = 4'b0001;
        step();
        total++;
        if ({enable, grant} !== {1'b0, 4'b0}) begin
            bad++;
            $display("FAIL b2b_turn2 got=%b required=%b",
                     {enable, grant}, {1'b0, 4'b0});
        end
        step();
        total++;
        if ({sel, enable, grant} !== {2'd0, 1'b1, 4'b0001}) begin
            bad++;
            $display("FAIL b2b_wrap got=%b required=%b",
                     {sel, enable, grant}, {2'd0, 1'b1, 4'b0001});
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef BUS_ARBITER_TIMEOUT_EN
        test_timeout_rotation();
        test_timeout_alone();
`else
        test_no_timeout();
`endif
        test_reset_mid_grant();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
